aes_byte_sequencer: RTL and testbench
=====================================

Name: aes_byte_sequencer

Overview:
- Controller that sequences the 8-bit-path AES-128 core (aes_8_bit) for a 128-bit request/response client.
- Accepts one {key, plaintext} request over valid/ready and restarts the core through its reset.
- Streams key and data into the core one byte per cycle, MSB byte first, then collects the 16 ciphertext bytes.
- Returns the 128-bit result, or an error on timeout or protocol violation. Sits between the AHB slave register file and the core.

Parameters:
- CORE_RST_CYCLES, 1, cycles core_rst is held high per operation (1..15).
- TIMEOUT_CYCLES, 512, max cycles from end of LOAD to core_done before error (≥32).
- TO_W, 10, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_key  in  128  cipher key; byte [127:120] is sent first.
- req_data  in  128  plaintext; byte [127:120] is sent first.
- resp_valid  out  1  result present.
- resp_ready  in  1  client accepts result.
- resp_data  out  128  ciphertext; first captured byte lands in [127:120].
- resp_err  out  1  qualifies resp_data as invalid (timeout or protocol error).
- busy  out  1  high in every state except IDLE.
- core_rst  out  1  drives the core's rst.
- core_key_in  out  8  core key byte.
- core_d_in  out  8  core data byte.
- core_d_out  in  8  core output byte.
- core_d_vld  in  1  core output byte valid.
- core_done  in  1  core completion.

Behaviour:
- Reset values (rst=1): state IDLE; req_ready=0 during the rst cycle, then 1; resp_valid=0, resp_err=0, resp_data=0, busy=0; core_rst=1; core_key_in=0, core_d_in=0; all counters 0.
- IDLE:
  - core_rst=1, so the core is held in reset while idle.
  - req_valid&req_ready latches key/data into internal registers, then → CRST.
- CRST: core_rst=1 for CORE_RST_CYCLES cycles, then → LOAD.
- LOAD: exactly 16 cycles.
  - core_rst=0; byte index i=0..15.
  - core_key_in=key_q[127-8i -: 8] and core_d_in=data_q[127-8i -: 8] during cycle i.
  - After i=15 → WAIT.
  - Outside LOAD, core_key_in and core_d_in are 0.
- WAIT / CAPT:
  - Every rising edge with core_d_vld=1 shifts res_q ← {res_q[119:0], core_d_out} and increments cap_cnt.
  - The first core_d_vld moves WAIT → CAPT.
  - cap_cnt reaching 16 → DONEW.
  - core_d_vld=0 inside CAPT before 16 bytes is a protocol error → RESP with err.
- DONEW:
  - core_d_vld is ignored (no further shifting).
  - core_done=1 → RESP with err=0.
- core_done=1 observed in WAIT or CAPT (fewer than 16 bytes) → RESP with err=1.
- Timeout:
  - Counter clears on entry to WAIT and increments each cycle in WAIT, CAPT and DONEW.
  - Reaching TIMEOUT_CYCLES → RESP with err=1.
  - A timeout and core_done in the same cycle: core_done wins.
- RESP:
  - resp_valid=1; resp_data=res_q if err=0, else 0; resp_err held stable.
  - core_rst=1 from RESP entry.
  - resp_valid&resp_ready → IDLE, with resp_valid and resp_err dropping next cycle.
  - No new request is accepted until the handshake completes (single outstanding operation).
- Latency: handshake at cycle 0 → core_rst high cycles 1..CORE_RST_CYCLES → LOAD bytes on the next 16 cycles → core latency → RESP entry the cycle after core_done.
- Request fields are sampled only at acceptance; changes during busy are ignored.
- rst mid-operation: immediate return to reset values next edge; captured bytes discarded; core_rst=1.
- req_valid held high while busy: no effect; req_ready stays 0.

Test Plan:
- Golden vector: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff → resp_data 69c4e0d86a7b0430d8cdb78070b4c55a, resp_err=0; core bytes 00/00 at LOAD i=0 and 0f/ff at i=15.
- FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734 → 3925841d02dc09fbdc118597196a0b32. Issued back-to-back after the first vector with resp_ready stalled 5 cycles: resp_data and resp_err stable during the stall; req_ready=0 until the response handshake.
- Core model that never raises core_d_vld, TIMEOUT_CYCLES=64 → resp_valid exactly 65 cycles after the last LOAD cycle, resp_err=1, resp_data=0.
- Core model pulsing core_done after 8 valid bytes → resp_err=1. Core model dropping core_d_vld after 10 bytes → resp_err=1.
- rst asserted for one cycle at LOAD i=7 → next cycle core_rst=1, busy=0, resp_valid=0. A fresh golden request then completes correctly.
- CORE_RST_CYCLES=3: core_rst high exactly 3 cycles after acceptance; the first LOAD byte appears on cycle 4; core_key_in and core_d_in are 0 in all non-LOAD cycles.

Source files
------------

// File: rtl/aes_byte_sequencer_if.sv
// Request/response bus between the AHB register file (master) and the
// AES byte sequencer (slave).
interface aes_byte_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_data;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_data;
  logic         resp_err;

  modport master (
    output req_valid, req_key, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_key, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/aes_byte_sequencer.sv
// Sequences the 8-bit-path AES-128 core: resets it, streams key/data bytes
// MSB first, collects 16 ciphertext bytes and returns them with error status.
module aes_byte_sequencer #(
  parameter int unsigned CORE_RST_CYCLES = 1,
  parameter int unsigned TIMEOUT_CYCLES  = 512,
  parameter int unsigned TO_W            = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  aes_byte_sequencer_if.slave        bus,
  output logic                       busy,
  output logic                       core_rst,
  output logic [7:0]                 core_key_in,
  output logic [7:0]                 core_d_in,
  input  logic [7:0]                 core_d_out,
  input  logic                       core_d_vld,
  input  logic                       core_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LOAD, S_WAIT, S_CAPT, S_DONEW, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    key_q, data_q, res_q;
  logic [3:0]      rst_cnt_q;
  logic [3:0]      idx_q;
  logic [4:0]      cap_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q, err_d;
  logic            accept, shift_en, timeout, last_byte;

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    accept    = bus.req_valid && bus.req_ready;
    shift_en  = ((state_q == S_WAIT) || (state_q == S_CAPT)) && core_d_vld;
    timeout   = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    last_byte = core_d_vld && (cap_cnt_q == 5'd15);

    case (state_q)
      S_IDLE:  if (accept) state_d = S_CRST;
      S_CRST:  if (rst_cnt_q == 4'(CORE_RST_CYCLES - 1)) state_d = S_LOAD;
      S_LOAD:  if (idx_q == 4'd15) state_d = S_WAIT;
      S_WAIT: begin
        if (core_done || timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else if (core_d_vld) begin
          state_d = S_CAPT;
        end
      end
      S_CAPT: begin
        // core_done wins over timeout; it is only good if this edge completes 16 bytes
        if (core_done) begin
          state_d = S_RESP;
          err_d   = !last_byte;
        end else if (timeout || !core_d_vld) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else if (last_byte) begin
          state_d = S_DONEW;
        end
      end
      S_DONEW: begin
        if (core_done) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_RESP:  if (bus.resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
      key_q     <= '0;
      data_q    <= '0;
      res_q     <= '0;
      rst_cnt_q <= '0;
      idx_q     <= '0;
      cap_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;

      if (accept) begin
        key_q     <= bus.req_key;
        data_q    <= bus.req_data;
        res_q     <= '0;
        cap_cnt_q <= '0;
      end

      if (state_q == S_CRST)
        rst_cnt_q <= (state_d == S_LOAD) ? '0 : rst_cnt_q + 4'd1;

      // Key/data shift left so the byte for the current index is always on top
      if (state_q == S_LOAD) begin
        idx_q  <= idx_q + 4'd1;
        key_q  <= {key_q[119:0], 8'h00};
        data_q <= {data_q[119:0], 8'h00};
      end

      if (state_q == S_LOAD)
        to_cnt_q <= '0;
      else if ((state_q == S_WAIT) || (state_q == S_CAPT) || (state_q == S_DONEW))
        to_cnt_q <= to_cnt_q + 1'b1;

      if (shift_en) begin
        res_q     <= {res_q[119:0], core_d_out};
        cap_cnt_q <= cap_cnt_q + 5'd1;
      end
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == S_IDLE) && !rst;
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_err   = (state_q == S_RESP) && err_q;
    bus.resp_data  = ((state_q == S_RESP) && !err_q) ? res_q : '0;
    busy           = (state_q != S_IDLE);
    core_rst       = (state_q == S_IDLE) || (state_q == S_CRST) || (state_q == S_RESP);
    core_key_in    = (state_q == S_LOAD) ? key_q[127:120]  : 8'h00;
    core_d_in      = (state_q == S_LOAD) ? data_q[127:120] : 8'h00;
  end

endmodule

// File: tb/tb_aes_byte_sequencer.sv
// Directed bench for aes_byte_sequencer with a behavioural core model that
// replays known ciphertext bytes or misbehaves on demand.
`timescale 1ns/1ps
module tb_aes_byte_sequencer;

  localparam int unsigned CRC = 3;
  localparam int unsigned TO  = 64;
  localparam int          S   = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy, core_rst;
  logic [7:0] core_key_in, core_d_in;
  logic [7:0] core_d_out = 8'h00;
  logic       core_d_vld = 1'b0;
  logic       core_done  = 1'b0;

  always #5 clk = ~clk;

  aes_byte_sequencer_if bus ();

  aes_byte_sequencer #(
    .CORE_RST_CYCLES(CRC),
    .TIMEOUT_CYCLES (TO),
    .TO_W           (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .core_rst   (core_rst),
    .core_key_in(core_key_in),
    .core_d_in  (core_d_in),
    .core_d_out (core_d_out),
    .core_d_vld (core_d_vld),
    .core_done  (core_done)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] data;
    logic [127:0] ct;
    int           nbytes;
    bit           done_en;
    bit           exp_err;
    int           stall;
    bit           chk_to;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc_g = 0;

  int           m_idx = 0;
  int           m_nbytes = 16;
  bit           m_done_en = 1'b1;
  logic [127:0] m_ct = '0;
  logic [7:0]   kcap [16];
  logic [7:0]   dcap [16];
  int           t_load0 = 0;
  int           t_load15 = 0;
  int           zero_viol = 0;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Core model: records LOAD bytes, emits ciphertext from cycle S after release
  always @(negedge clk) begin
    if (core_rst) begin
      if (core_key_in != 8'h00 || core_d_in != 8'h00) zero_viol <= zero_viol + 1;
      m_idx      <= 0;
      core_d_vld <= 1'b0;
      core_done  <= 1'b0;
      core_d_out <= 8'h00;
    end else begin
      if (m_idx < 16) begin
        kcap[m_idx] <= core_key_in;
        dcap[m_idx] <= core_d_in;
        if (m_idx == 0)  t_load0  <= cyc_g;
        if (m_idx == 15) t_load15 <= cyc_g;
      end else if (core_key_in != 8'h00 || core_d_in != 8'h00) begin
        zero_viol <= zero_viol + 1;
      end
      if (m_idx >= S && m_idx < S + m_nbytes) begin
        core_d_vld <= 1'b1;
        core_d_out <= 8'(m_ct >> (8 * (15 - (m_idx - S))));
      end else begin
        core_d_vld <= 1'b0;
        core_d_out <= 8'h00;
      end
      core_done <= m_done_en && (m_idx == S + m_nbytes);
      m_idx <= m_idx + 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (time limit)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic send_req(input logic [127:0] k, input logic [127:0] d,
                          output int t_acc, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    t_acc = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", bus.req_ready, 1'b1);
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1;
    bus.req_key   = k;
    bus.req_data  = d;
    t_acc = cyc_g;
    ok = 1'b1;
    @(negedge clk);
    // Held valid with different fields while busy must be ignored
    bus.req_key  = ~k;
    bus.req_data = ~d;
    chk("req_ready_busy", {bus.req_ready, busy}, 2'b01);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_key   = '0;
    bus.req_data  = '0;
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int           t_acc, t_resp, n;
    bit           ok;
    logic [127:0] kc, dc, hold_d;
    logic         hold_e, stable;
    m_ct      = v.ct;
    m_nbytes  = v.nbytes;
    m_done_en = v.done_en;
    send_req(v.key, v.data, t_acc, ok);
    if (!ok) return;
    n = 0;
    while (!bus.resp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("v%0d_resp_wait", id), bus.resp_valid, 1'b1);
    if (!bus.resp_valid) return;
    t_resp = cyc_g;
    chk($sformatf("v%0d_resp_data", id), bus.resp_data, v.exp_err ? 128'h0 : v.ct);
    chk($sformatf("v%0d_resp_err", id), bus.resp_err, v.exp_err);
    chk($sformatf("v%0d_load_start", id), t_load0 - t_acc, CRC + 1);
    for (int j = 0; j < 16; j++) begin
      kc[127 - 8*j -: 8] = kcap[j];
      dc[127 - 8*j -: 8] = dcap[j];
    end
    chk($sformatf("v%0d_load_key", id), kc, v.key);
    chk($sformatf("v%0d_load_data", id), dc, v.data);
    if (v.chk_to) chk($sformatf("v%0d_timeout_lat", id), t_resp - t_load15, TO + 1);
    if (v.stall > 0) begin
      hold_d = bus.resp_data;
      hold_e = bus.resp_err;
      bus.req_valid = 1'b1;
      bus.req_key   = '1;
      bus.req_data  = '1;
      for (int i = 0; i < v.stall; i++) begin
        @(negedge clk);
        stable = bus.resp_valid && (bus.resp_data == hold_d) &&
                 (bus.resp_err == hold_e) && !bus.req_ready;
        chk($sformatf("v%0d_stall%0d", id, i), stable, 1'b1);
      end
      bus.req_valid = 1'b0;
      bus.req_key   = '0;
      bus.req_data  = '0;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk($sformatf("v%0d_resp_drop", id), {bus.resp_valid, bus.resp_err, busy}, 3'b000);
  endtask

  vec_t vecs [5];

  initial begin
    int t_acc;
    bit ok;

    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f, data: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, nbytes: 16, done_en: 1'b1,
                exp_err: 1'b0, stall: 0, chk_to: 1'b0};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, data: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, nbytes: 16, done_en: 1'b1,
                exp_err: 1'b0, stall: 5, chk_to: 1'b0};
    vecs[2] = '{key: 128'h000102030405060708090a0b0c0d0e0f, data: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, nbytes: 0, done_en: 1'b0,
                exp_err: 1'b1, stall: 0, chk_to: 1'b1};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, data: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, nbytes: 8, done_en: 1'b1,
                exp_err: 1'b1, stall: 0, chk_to: 1'b0};
    vecs[4] = '{key: 128'h000102030405060708090a0b0c0d0e0f, data: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, nbytes: 10, done_en: 1'b0,
                exp_err: 1'b1, stall: 0, chk_to: 1'b0};

    bus.req_valid  = 1'b0;
    bus.req_key    = '0;
    bus.req_data   = '0;
    bus.resp_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1'b0);
    chk("rst_outputs", {bus.resp_valid, bus.resp_err, busy, core_rst}, 4'b0001);
    chk("rst_resp_data", bus.resp_data, 128'h0);
    chk("rst_core_bytes", {core_key_in, core_d_in}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", bus.req_ready, 1'b1);

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset in the middle of LOAD byte 7, then a fresh golden request
    m_ct      = vecs[0].ct;
    m_nbytes  = 16;
    m_done_en = 1'b1;
    send_req(vecs[0].key, vecs[0].data, t_acc, ok);
    if (ok) begin
      repeat (9) @(negedge clk);
      chk("midload_byte7", {core_key_in, core_d_in, core_rst}, {8'h07, 8'h77, 1'b0});
      rst = 1'b1;
      @(negedge clk);
      chk("midload_rst_state", {core_rst, busy, bus.resp_valid, bus.resp_err}, 4'b1000);
      rst = 1'b0;
      run_vec(5, vecs[0]);
    end

    repeat (2) @(negedge clk);
    chk("zero_outside_load", zero_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
